// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO peripheral: register offsets, register-select
// decode over mem_addr[4:2], and the debounce counter width.
package gpio_pkg;

   localparam logic [4:0] GPIO_OUT_OFF     = 5'h00;
   localparam logic [4:0] GPIO_DIR_OFF     = 5'h04;
   localparam logic [4:0] GPIO_IN_OFF      = 5'h08;
   localparam logic [4:0] GPIO_RISE_EN_OFF = 5'h0C;
   localparam logic [4:0] GPIO_FALL_EN_OFF = 5'h10;
   localparam logic [4:0] GPIO_PEND_OFF    = 5'h14;
   localparam logic [4:0] GPIO_IRQ_EN_OFF  = 5'h18;
   localparam logic [4:0] GPIO_RSVD_OFF    = 5'h1C;

   localparam int GPIO_DEB_CNT_W = 16;

   typedef enum logic [2:0] {
      SEL_OUT     = GPIO_OUT_OFF[4:2],
      SEL_DIR     = GPIO_DIR_OFF[4:2],
      SEL_IN      = GPIO_IN_OFF[4:2],
      SEL_RISE_EN = GPIO_RISE_EN_OFF[4:2],
      SEL_FALL_EN = GPIO_FALL_EN_OFF[4:2],
      SEL_PEND    = GPIO_PEND_OFF[4:2],
      SEL_IRQ_EN  = GPIO_IRQ_EN_OFF[4:2],
      SEL_RSVD    = GPIO_RSVD_OFF[4:2]
   } gpio_sel_e;

endpackage

// File: rtl/gpio_in_filter.sv
// Per-line input conditioning: 2-flop synchronizer, plus a stability-window
// debounce filter when GPIO_DEBOUNCE_EN is defined.
module gpio_in_filter
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pad_i,
   output logic filt_o
);

   logic sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pad_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam logic [GPIO_DEB_CNT_W-1:0] CNT_MAX = GPIO_DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [GPIO_DEB_CNT_W-1:0] cnt_q, cnt_d;
   logic                      filt_q, filt_d;

   // Count consecutive cycles of disagreement; any agreement restarts the window.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_MAX) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + GPIO_DEB_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt_o = filt_q;
`else
   // Debounce window has no effect in this build.
   if (DEBOUNCE_CYCLES < 2) begin : g_unused_debounce
   end

   assign filt_o = sync2_q;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: OUT/DIR pad drive, synchronized input, rise/fall edge
// capture into sticky W1C PEND, level irq. Optional debounce via GPIO_DEBOUNCE_EN.
module gpio_ctrl
   import gpio_pkg::*;
#(
   parameter int NUM_GPIO        = 1,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mem_valid,
   output logic                mem_ready,
   input  logic [4:0]          mem_addr,
   input  logic [3:0]          mem_wstrb,
   input  logic [31:0]         mem_wdata,
   output logic [31:0]         mem_rdata,
   input  logic [NUM_GPIO-1:0] gpio_in,
   output logic [NUM_GPIO-1:0] gpio_out,
   output logic [NUM_GPIO-1:0] gpio_oe,
   output logic                irq
);

   typedef logic [NUM_GPIO-1:0] vec_t;

   vec_t out_q, out_d, dir_q, dir_d;
   vec_t rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   vec_t pend_q, pend_d, irq_en_q, irq_en_d, prev_q, prev_d;
   vec_t filt, rise, fall, clr;
   logic        irq_q, irq_d, mem_ready_q, mem_ready_d;
   logic [31:0] mem_rdata_q, mem_rdata_d, rd_val, lane_mask;
   logic        accept, wr_en;
   gpio_sel_e   sel;
   logic [1:0]  unused_addr_lsb;

   assign unused_addr_lsb = mem_addr[1:0];

   function automatic logic [31:0] widen(input vec_t v);
      logic [31:0] r;
      r = '0;
      r[NUM_GPIO-1:0] = v;
      return r;
   endfunction

   function automatic logic [31:0] strb_to_mask(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
      return m;
   endfunction

   function automatic vec_t merge_bytes(input vec_t old, input logic [31:0] wd,
                                        input logic [31:0] m);
      logic [31:0] r;
      r = (widen(old) & ~m) | (wd & m);
      return r[NUM_GPIO-1:0];
   endfunction

   for (genvar i = 0; i < NUM_GPIO; i++) begin : g_in
      gpio_in_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt (
         .clk    (clk),
         .rst_n  (rst_n),
         .pad_i  (gpio_in[i]),
         .filt_o (filt[i])
      );
   end

   always_comb begin
      sel        = gpio_sel_e'(mem_addr[4:2]);
      accept     = mem_valid & ~mem_ready_q;
      wr_en      = accept & (mem_wstrb != 4'b0000);
      lane_mask  = strb_to_mask(mem_wstrb);
      out_d      = out_q;
      dir_d      = dir_q;
      rise_en_d  = rise_en_q;
      fall_en_d  = fall_en_q;
      irq_en_d   = irq_en_q;
      clr        = '0;
      rd_val     = '0;

      case (sel)
         SEL_OUT:     rd_val = widen(out_q);
         SEL_DIR:     rd_val = widen(dir_q);
         SEL_IN:      rd_val = widen(filt);
         SEL_RISE_EN: rd_val = widen(rise_en_q);
         SEL_FALL_EN: rd_val = widen(fall_en_q);
         SEL_PEND:    rd_val = widen(pend_q);
         SEL_IRQ_EN:  rd_val = widen(irq_en_q);
         default:     rd_val = '0;
      endcase

      if (wr_en) begin
         case (sel)
            SEL_OUT:     out_d     = merge_bytes(out_q, mem_wdata, lane_mask);
            SEL_DIR:     dir_d     = merge_bytes(dir_q, mem_wdata, lane_mask);
            SEL_RISE_EN: rise_en_d = merge_bytes(rise_en_q, mem_wdata, lane_mask);
            SEL_FALL_EN: fall_en_d = merge_bytes(fall_en_q, mem_wdata, lane_mask);
            SEL_IRQ_EN:  irq_en_d  = merge_bytes(irq_en_q, mem_wdata, lane_mask);
            SEL_PEND:    clr       = mem_wdata[NUM_GPIO-1:0] & lane_mask[NUM_GPIO-1:0];
            default:     ;
         endcase
      end

      // A fresh edge on the same bit as a W1C clear keeps the bit set.
      rise        = filt & ~prev_q & rise_en_q;
      fall        = ~filt & prev_q & fall_en_q;
      pend_d      = (pend_q & ~clr) | rise | fall;
      prev_d      = filt;
      irq_d       = |(pend_q & irq_en_q);
      mem_ready_d = accept;
      mem_rdata_d = accept ? rd_val : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         dir_q       <= '0;
         rise_en_q   <= '0;
         fall_en_q   <= '0;
         pend_q      <= '0;
         irq_en_q    <= '0;
         prev_q      <= '0;
         irq_q       <= 1'b0;
         mem_ready_q <= 1'b0;
         mem_rdata_q <= '0;
      end else begin
         out_q       <= out_d;
         dir_q       <= dir_d;
         rise_en_q   <= rise_en_d;
         fall_en_q   <= fall_en_d;
         pend_q      <= pend_d;
         irq_en_q    <= irq_en_d;
         prev_q      <= prev_d;
         irq_q       <= irq_d;
         mem_ready_q <= mem_ready_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign gpio_out  = out_q;
   assign gpio_oe   = dir_q;
   assign irq       = irq_q;
   assign mem_ready = mem_ready_q;
   assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl (4 lines); debounce scenario runs when
// GPIO_DEBOUNCE_EN is defined.
module tb_gpio_ctrl;

   localparam int NG = 4;
`ifdef GPIO_DEBOUNCE_EN
   localparam int IN_LAT = 2 + 4;
`else
   localparam int IN_LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_valid;
   logic          mem_ready;
   logic [4:0]    mem_addr;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic [NG-1:0] gpio_in;
   logic [NG-1:0] gpio_out;
   logic [NG-1:0] gpio_oe;
   logic          irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] mreg [5];

   gpio_ctrl #(.NUM_GPIO(NG), .DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .gpio_oe   (gpio_oe),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Runs one transaction; returns just after the ack edge.
   task automatic bus_xfer(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
      int k;
      mem_addr  = a;
      mem_wdata = d;
      mem_wstrb = s;
      mem_valid = 1'b1;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (mem_ready !== 1'b1 && k < 8);
      rd        = mem_rdata;
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      n_checks++;
      if (mem_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bus_ack addr=%h: mem_ready=%b after %0d cycles, required 1", a, mem_ready, k);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] unused_rd;
      bus_xfer(a, d, s, unused_rd);
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      bus_xfer(a, 32'h0, 4'b0000, d);
   endtask

   function automatic logic [4:0] rw_addr(input int idx);
      case (idx)
         0:       return 5'h00;
         1:       return 5'h04;
         2:       return 5'h0C;
         3:       return 5'h10;
         default: return 5'h18;
      endcase
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b0;
      tick(3);
      n_checks++;
      if ({gpio_oe, gpio_out, irq, mem_ready} !== '0 || mem_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: oe=%h out=%h irq=%b rdy=%b rdata=%h, required all 0",
                  gpio_oe, gpio_out, irq, mem_ready, mem_rdata);
      end
      rst_n = 1'b1;
      tick(1);
      for (int i = 0; i < 7; i++) begin
         rd(5'(i * 4), d);
         n_checks++;
         if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read off=%h: got %h, required 0", 5'(i * 4), d);
         end
      end
      for (int i = 0; i < 5; i++) mreg[i] = 4'h0;
   endtask

   task automatic test_output_strobes();
      logic [31:0] d;
      wr(5'h04, 32'h1, 4'b1111);
      tick(1);
      mem_addr  = 5'h00;
      mem_wdata = 32'h1;
      mem_wstrb = 4'b0001;
      mem_valid = 1'b1;
      tick(1);
      n_checks++;
      if (mem_ready !== 1'b1 || gpio_out !== 4'h1 || gpio_oe !== 4'h1) begin
         n_fail++;
         $display("FAIL ack_edge_drive: rdy=%b out=%h oe=%h, required 1/1/1", mem_ready, gpio_out, gpio_oe);
      end
      tick(1);
      n_checks++;
      if (mem_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_one_cycle: mem_ready=%b with valid held, required 0", mem_ready);
      end
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      wr(5'h00, 32'hFFFF_FF00, 4'b0010);
      rd(5'h00, d);
      n_checks++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL strobe_lane1: OUT=%h, required 1", d);
      end
      wr(5'h00, 32'hFFFF_FFFF, 4'b0001);
      rd(5'h00, d);
      n_checks++;
      if (d !== 32'hF || gpio_out !== 4'hF) begin
         n_fail++;
         $display("FAIL upper_bits: OUT=%h pad=%h, required 0000000f/f", d, gpio_out);
      end
      wr(5'h1C, 32'hFFFF_FFFF, 4'b1111);
      rd(5'h1C, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL reserved_read: got %h, required 0", d);
      end
      mreg[0] = 4'hF;
      mreg[1] = 4'h1;
   endtask

   task automatic test_register_rw();
      logic [31:0] d, wd;
      logic [3:0]  s;
      int          idx;
      for (int n = 0; n < 16; n++) begin
         idx = $urandom_range(0, 4);
         wd  = $urandom;
         s   = 4'($urandom_range(1, 15));
         wr(rw_addr(idx), wd, s);
         // Only byte lane 0 carries the four implemented bits.
         if (s[0]) mreg[idx] = wd[3:0];
         rd(rw_addr(idx), d);
         n_checks++;
         if (d !== {28'h0, mreg[idx]}) begin
            n_fail++;
            $display("FAIL reg_rw addr=%h strb=%b: got %h, required %h", rw_addr(idx), s, d, mreg[idx]);
         end
      end
      n_checks++;
      if (gpio_out !== mreg[0] || gpio_oe !== mreg[1]) begin
         n_fail++;
         $display("FAIL pad_drive: out=%h oe=%h, required %h/%h", gpio_out, gpio_oe, mreg[0], mreg[1]);
      end
      rd(5'h08, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL in_idle: IN=%h, required 0", d);
      end
   endtask

   task automatic test_rise_edge();
      logic [31:0] d;
      wr(5'h0C, 32'h1, 4'b1111);
      wr(5'h10, 32'h0, 4'b1111);
      wr(5'h18, 32'h1, 4'b1111);
      wr(5'h14, 32'hF, 4'b1111);
      tick(IN_LAT + 4);
      gpio_in[0] = 1'b1;
      tick(IN_LAT - 1);
      rd(5'h08, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL in_not_early: IN=%h one cycle before latency, required 0", d);
      end
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_not_early: irq=%b at PEND-set edge, required 0", irq);
      end
      rd(5'h08, d);
      n_checks++;
      if (d !== 32'h1 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL rise_in_irq: IN=%h irq=%b, required 1/1", d, irq);
      end
      rd(5'h14, d);
      n_checks++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL rise_pend: PEND=%h, required 1", d);
      end
      wr(5'h14, 32'h1, 4'b0001);
      gpio_in[0] = 1'b0;
      tick(IN_LAT + 6);
      rd(5'h14, d);
      n_checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL fall_disabled: PEND=%h irq=%b, required 0/0", d, irq);
      end
   endtask

   task automatic test_clear_race();
      logic [31:0] d;
      gpio_in[0] = 1'b1;
      tick(IN_LAT + 4);
      gpio_in[0] = 1'b0;
      tick(IN_LAT + 6);
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL race_setup: irq=%b, required 1", irq);
      end
      gpio_in[0] = 1'b1;
      tick(IN_LAT);
      wr(5'h14, 32'h1, 4'b0001);
      tick(1);
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL race_irq: irq=%b after W1C coinciding with edge, required 1", irq);
      end
      rd(5'h14, d);
      n_checks++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL race_pend: PEND=%h, required 1", d);
      end
      tick(1);
      wr(5'h14, 32'h1, 4'b0001);
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL w1c_irq: irq=%b cycle after clear, required 0", irq);
      end
      rd(5'h14, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL w1c_pend: PEND=%h, required 0", d);
      end
      gpio_in = '0;
      tick(IN_LAT + 6);
   endtask

`ifndef GPIO_DEBOUNCE_EN
   task automatic test_random_edges();
      logic [31:0] d;
      logic [3:0]  re, fe, ie, exp, prv, v;
      int          len;
      for (int r = 0; r < 10; r++) begin
         re = 4'($urandom);
         fe = 4'($urandom);
         ie = 4'($urandom);
         wr(5'h0C, {28'h0, re}, 4'b0001);
         wr(5'h10, {28'h0, fe}, 4'b0001);
         wr(5'h18, {28'h0, ie}, 4'b0001);
         wr(5'h14, 32'hF, 4'b0001);
         tick(3);
         exp = 4'h0;
         prv = gpio_in;
         len = $urandom_range(1, 12);
         for (int j = 0; j < len; j++) begin
            v = 4'($urandom);
            exp = exp | (v & ~prv & re) | (~v & prv & fe);
            prv = v;
            gpio_in = v;
            tick(1);
         end
         tick(5);
         rd(5'h14, d);
         n_checks++;
         if (d !== {28'h0, exp}) begin
            n_fail++;
            $display("FAIL rand_pend round %0d: PEND=%h, required %h", r, d, exp);
         end
         rd(5'h08, d);
         n_checks++;
         if (d !== {28'h0, prv} || irq !== |(exp & ie)) begin
            n_fail++;
            $display("FAIL rand_in_irq round %0d: IN=%h irq=%b, required %h/%b", r, d, irq, prv, |(exp & ie));
         end
      end
      gpio_in = '0;
      tick(6);
      wr(5'h14, 32'hF, 4'b0001);
   endtask
`else
   task automatic test_debounce();
      logic [31:0] d;
      wr(5'h0C, 32'h1, 4'b0001);
      wr(5'h10, 32'h0, 4'b0001);
      wr(5'h18, 32'h1, 4'b0001);
      wr(5'h14, 32'hF, 4'b0001);
      tick(4);
      gpio_in[0] = 1'b1;
      tick(3);
      gpio_in[0] = 1'b0;
      tick(12);
      rd(5'h08, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL short_pulse_in: IN=%h, required 0", d);
      end
      rd(5'h14, d);
      n_checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL short_pulse_pend: PEND=%h irq=%b, required 0/0", d, irq);
      end
      tick(2);
      gpio_in[0] = 1'b1;
      tick(5);
      rd(5'h08, d);
      gpio_in[0] = 1'b0;
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL long_pulse_early: IN=%h before window, required 0", d);
      end
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL long_pulse_irq_early: irq=%b, required 0", irq);
      end
      rd(5'h08, d);
      n_checks++;
      if (d !== 32'h1 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL long_pulse: IN=%h irq=%b, required 1/1", d, irq);
      end
      tick(16);
      wr(5'h14, 32'hF, 4'b0001);
   endtask
`endif

   task automatic test_reset_mid_transaction();
      logic [31:0] d;
      wr(5'h00, 32'h2, 4'b0001);
      tick(2);
      mem_addr  = 5'h00;
      mem_wdata = 32'h1;
      mem_wstrb = 4'b1111;
      mem_valid = 1'b1;
      rst_n     = 1'b0;
      tick(1);
      n_checks++;
      if (mem_ready !== 1'b0 || gpio_out !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_mid: rdy=%b out=%h, required 0/0", mem_ready, gpio_out);
      end
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      rst_n     = 1'b1;
      tick(1);
      n_checks++;
      if (mem_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_noack: mem_ready=%b, required 0", mem_ready);
      end
      rd(5'h00, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_out: OUT=%h, required 0", d);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wstrb = '0;
      mem_wdata = '0;
      gpio_in   = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_output_strobes();
      test_register_rw();
      test_rise_edge();
      test_clear_race();
`ifndef GPIO_DEBOUNCE_EN
      test_random_edges();
`else
      test_debounce();
`endif
      test_reset_mid_transaction();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Memory-mapped GPIO peripheral inside the SoC.
- Produces gpio_out/gpio_oe and consumes gpio_in, which the chip top maps onto the spare bidirectional pad.
- Provides a 2-flop input synchronizer, rise/fall edge capture, a sticky interrupt pending register, and a simple valid/ready register bus matching the SoC's native memory interface.

Parameters:
- NUM_GPIO, 1, number of GPIO lines (1..32); register bits at and above NUM_GPIO read 0 and ignore writes.
- DEBOUNCE_CYCLES, 16, stability window in clocks; used only when GPIO_DEBOUNCE_EN is defined (2..65535).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- mem_valid  input  1  bus request, held until mem_ready
- mem_ready  output  1  one-cycle acknowledge
- mem_addr  input  5  byte address; bits [4:2] select the register
- mem_wstrb  input  4  byte write strobes; 0 = read
- mem_wdata  input  32  write data
- mem_rdata  output  32  read data, valid while mem_ready=1, else 0
- gpio_in  input  NUM_GPIO  raw pad input (asynchronous)
- gpio_out  output  NUM_GPIO  pad output value
- gpio_oe  output  NUM_GPIO  pad output enable; 1 = drive
- irq  output  1  level interrupt to the CPU

Behaviour:
- Register map (word offsets):
  - 0x00 OUT, RW
  - 0x04 DIR, RW, 1 = output
  - 0x08 IN, RO, filtered synchronized input
  - 0x0C RISE_EN, RW
  - 0x10 FALL_EN, RW
  - 0x14 PEND, read / write-1-to-clear
  - 0x18 IRQ_EN, RW
  - 0x1C: reads 0, writes ignored, still acknowledged
- Reset (rst_n=0 at a clk edge): every register, the sync/filter flops, mem_ready and mem_rdata go to 0. Therefore gpio_out=0, gpio_oe=0 (all pads inputs) and irq=0.
- Handshake:
  - Request accepted on a cycle with mem_valid=1 and mem_ready=0.
  - Write commit and the mem_ready=1 pulse both occur at the next clk edge, so latency is 1 cycle.
  - mem_ready is high for exactly one cycle; no back-to-back acks.
  - The master must hold mem_valid and all request fields stable until the ack. A transaction therefore occupies 2 cycles minimum.
- Reset mid-transaction: pending request is discarded, no write occurs, mem_ready=0.
- Byte strobes: each set strobe bit updates its byte lane only. Reads return the register value registered at acceptance.
- Pad drive: gpio_out=OUT and gpio_oe=DIR, both registered outputs with no extra delay.
- Input path:
  - sync1 <= gpio_in; sync2 <= sync1; filt = sync2 (when debounce is off); prev <= filt.
  - IN reflects a pad change 2 cycles after it.
- Edge capture:
  - rise = filt & ~prev & RISE_EN; fall = ~filt & prev & FALL_EN.
  - PEND <= (PEND & ~clr) | rise | fall, where clr is the W1C mask of an accepted PEND write.
  - If an edge and a clear of the same bit occur together, set wins.
- Interrupt: irq is registered, irq <= |(PEND & IRQ_EN); it rises 1 cycle after PEND sets.
- Input pads configured as outputs: still sampled, so loopback edges are captured.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- When defined:
  - Each line has a 16-bit counter. When sync2 != filt the counter increments, otherwise it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1, filt <= sync2 and the counter resets.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
  - Edge detection and IN use filt, so IN latency = 2 + DEBOUNCE_CYCLES cycles.
- When undefined: filt = sync2 and no counter logic is synthesized.

Decomposition:
- Package gpio_pkg holds:
  - register offset localparams (GPIO_OUT_OFF … GPIO_IRQ_EN_OFF)
  - the register-select enum over addr[4:2]
  - the debounce counter width constant (16)
- One sub-module, gpio_in_filter (per-bit synchronizer plus optional debounce), instantiated NUM_GPIO times via generate.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, then check:
  - gpio_oe=0, gpio_out=0, irq=0
  - reads of 0x00–0x18 all return 0
- Output and byte strobes:
  - Write DIR=0x1, then OUT=0x1 with wstrb=4'b0001: gpio_oe=1 and gpio_out=1 on the ack edge, mem_ready high for exactly 1 cycle.
  - Write with wstrb=4'b0010: OUT unchanged.
- Rising edge:
  - Set RISE_EN=1 and IRQ_EN=1, then toggle gpio_in 0→1 at cycle T.
  - Expect IN=1 readable from T+2, PEND[0]=1 at T+3, irq=1 at T+4.
  - A falling edge with FALL_EN=0 leaves PEND unchanged.
- Clear race:
  - Write PEND=0x1 whose commit edge coincides with a new rising edge: PEND[0] stays 1 and irq stays 1.
  - A plain W1C later: PEND=0 and irq=0 on the next cycle.
- Reset mid-transaction:
  - Assert mem_valid with a write OUT=1, and pull rst_n=0 on the acceptance cycle.
  - Expect no ack and OUT=0 after reset.
- Debounce (GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4):
  - A 3-cycle pulse on gpio_in: no IN change and no PEND.
  - A 6-cycle pulse: IN=1 at T+6 and PEND set at T+7.
